// File: rtl/seq_ctrl_pkg.sv
// Shared types, default widths and the step-direction helper for sequence_counter_ctrl.
// SEQ_CTRL_DOWN_EN selects down-counting whenever the latched first value exceeds last.
package seq_ctrl_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_PASS_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Returns 1 when the counter should decrement; without the option it always increments
  // and an inverted range is covered by wrapping through the top of the count space.
  function automatic logic step_down(input logic [31:0] first, input logic [31:0] last);
    logic gt;
    gt = (first > last);
`ifdef SEQ_CTRL_DOWN_EN
    return gt;
`else
    return 1'b0 & gt;
`endif
  endfunction

endpackage

// File: rtl/seq_step_counter.sv
// WIDTH-bit sequence counter register with load, enable, direction and terminal match.
// Direction policy comes from the caller; the build option SEQ_CTRL_DOWN_EN is resolved upstream.
module seq_step_counter
  import seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             down,
  input  logic [WIDTH-1:0] last_value,
  output logic [WIDTH-1:0] value,
  output logic             at_last
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (enable) begin
      value <= down ? value - WIDTH'(1) : value + WIDTH'(1);
    end
  end

  assign at_last = (value == last_value);

endmodule

// File: rtl/sequence_counter_ctrl.sv
// Bounded, restartable sequence controller: runs a counter first..last for a number of passes.
// Build option SEQ_CTRL_DOWN_EN: count down when the latched first value is above last.
module sequence_counter_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int PASS_W = DEF_PASS_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  cfg_first,
  input  logic [WIDTH-1:0]  cfg_last,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic              pause,
  input  logic              abort,
  output logic [WIDTH-1:0]  counter,
  output logic [PASS_W-1:0] pass_idx,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  first_q, last_q;
  logic [PASS_W-1:0] passes_q, last_pass;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic              latch_cfg, cnt_load, cnt_en, cnt_down, at_last;
  logic [WIDTH-1:0]  load_value;

  // A programmed pass count of zero behaves as a single pass.
  assign last_pass = (passes_q == '0) ? '0 : passes_q - PASS_W'(1);
  assign cnt_down  = step_down(32'(first_q), 32'(last_q));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pass_q   <= '0;
      first_q  <= '0;
      last_q   <= '0;
      passes_q <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      if (latch_cfg) begin
        first_q  <= cfg_first;
        last_q   <= cfg_last;
        passes_q <= cfg_passes;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    latch_cfg  = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    load_value = first_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          latch_cfg  = 1'b1;
          cnt_load   = 1'b1;
          load_value = cfg_first;
          pass_d     = '0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_RUN;
        end else if (!at_last) begin
          cnt_en = 1'b1;
        end else if (pass_q == last_pass) begin
          state_d = ST_DONE;
        end else begin
          cnt_load = 1'b1;
          pass_d   = pass_q + PASS_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  seq_step_counter #(.WIDTH(WIDTH)) u_step (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (load_value),
    .enable     (cnt_en),
    .down       (cnt_down),
    .last_value (last_q),
    .value      (counter),
    .at_last    (at_last)
  );

  // Status outputs decode registered state only.
  assign pass_idx = pass_q;
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_sequence_counter_ctrl.sv
// Directed self-checking bench for sequence_counter_ctrl (default WIDTH=4, PASS_W=4).
// Expected values follow the build option SEQ_CTRL_DOWN_EN when it is defined.
module tb_sequence_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, pause, abort;
  logic [3:0] cfg_first, cfg_last, cfg_passes;
  logic [3:0] counter, pass_idx;
  logic       busy, done;

  int n_assert = 0;
  int n_fail   = 0;
  int bc, rem, seen;

  sequence_counter_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_first  (cfg_first),
    .cfg_last   (cfg_last),
    .cfg_passes (cfg_passes),
    .pause      (pause),
    .abort      (abort),
    .counter    (counter),
    .pass_idx   (pass_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run, then scramble the config inputs to show they are only used on the latch edge.
  task automatic do_start(input int first, input int last, input int passes);
    cfg_first  = first[3:0];
    cfg_last   = last[3:0];
    cfg_passes = passes[3:0];
    start      = 1'b1;
    tick();
    start      = 1'b0;
    cfg_first  = 4'hA;
    cfg_last   = 4'hB;
    cfg_passes = 4'h7;
  endtask

  // Walk an unpaused run cycle by cycle from the start edge through done and back to idle.
  task automatic expect_run(input string tag, input int first, input int last, input int passes,
                            input bit down, output int busy_cnt);
    logic [3:0] v;
    int np;
    bit end_pass;
    np = (passes == 0) ? 1 : passes;
    busy_cnt = 0;
    for (int p = 0; p < np; p++) begin
      v = first[3:0];
      end_pass = 1'b0;
      for (int k = 0; k < 16 && !end_pass; k++) begin
        check({tag, "_cnt"}, counter, v);
        check({tag, "_pass"}, pass_idx, p);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_nodone"}, done, 0);
        busy_cnt++;
        if (v == last[3:0]) end_pass = 1'b1;
        else v = down ? v - 4'd1 : v + 4'd1;
        tick();
      end
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_done_busy"}, busy, 0);
    check({tag, "_done_cnt"}, counter, last[3:0]);
    check({tag, "_done_pass"}, pass_idx, np - 1);
    tick();
    check({tag, "_idle_done"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  // Tick until done, counting busy cycles; bounded so a stuck DUT cannot hang the run.
  task automatic run_count(output int busy_cnt, output int done_seen);
    busy_cnt  = 0;
    done_seen = 0;
    for (int k = 0; k < 100 && done_seen == 0; k++) begin
      tick();
      if (busy) busy_cnt++;
      if (done) done_seen = 1;
    end
  endtask

  initial begin
    // Reset held two cycles with start asserted.
    reset = 1'b0; start = 1'b1; pause = 1'b0; abort = 1'b0;
    cfg_first = 4'd2; cfg_last = 4'd5; cfg_passes = 4'd1;
    tick(); tick();
    check("rst_counter", counter, 0);
    check("rst_pass", pass_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b1; start = 1'b0;
    tick();
    check("idle_busy", busy, 0);
    check("idle_counter", counter, 0);

    // 2..5, single pass.
    do_start(2, 5, 1);
    expect_run("t1", 2, 5, 1, 1'b0, bc);
    check("t1_busy_cycles", bc, 4);

    // 0..3, three passes.
    do_start(0, 3, 3);
    expect_run("t2", 0, 3, 3, 1'b0, bc);
    check("t2_busy_cycles", bc, 12);

    // Same run with a three-cycle pause while counter=2 in pass 0.
    do_start(0, 3, 3);
    check("p_c0", counter, 0);
    tick(); check("p_c1", counter, 1);
    tick(); check("p_c2", counter, 2);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("p_hold_cnt", counter, 2);
      check("p_hold_busy", busy, 1);
    end
    pause = 1'b0;
    tick(); check("p_resume", counter, 3);
    run_count(rem, seen);
    check("p_done_seen", seen, 1);
    check("p_busy_total", 7 + rem, 15);
    check("p_done_pass", pass_idx, 2);
    tick();
    check("p_idle_done", done, 0);

    // start pulsed mid-run with different config is ignored.
    do_start(0, 3, 1);
    check("sr_c0", counter, 0);
    tick(); check("sr_c1", counter, 1);
    start = 1'b1; cfg_first = 4'd8; cfg_last = 4'd8;
    tick();
    start = 1'b0;
    check("sr_c2", counter, 2);
    check("sr_busy", busy, 1);
    tick(); check("sr_c3", counter, 3);
    tick(); check("sr_done", done, 1);
    tick(); check("sr_idle", busy, 0);
    check("sr_idle_done", done, 0);

    // Abort at counter=1, then restart on the very next cycle.
    do_start(0, 7, 1);
    check("ab_c0", counter, 0);
    tick(); check("ab_c1", counter, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    check("ab_cnt_hold", counter, 1);
    check("ab_pass_hold", pass_idx, 0);

    // first==last with passes=0 gives one RUN cycle.
    do_start(9, 9, 0);
    expect_run("eq", 9, 9, 0, 1'b0, bc);
    check("eq_busy_cycles", bc, 1);

    // Inverted range 14 -> 1.
    do_start(14, 1, 1);
`ifdef SEQ_CTRL_DOWN_EN
    expect_run("wrap", 14, 1, 1, 1'b1, bc);
    check("wrap_busy_cycles", bc, 14);
`else
    expect_run("wrap", 14, 1, 1, 1'b0, bc);
    check("wrap_busy_cycles", bc, 4);
`endif

    // Reset mid-run overrides pause and abort.
    do_start(4, 10, 2);
    tick(); tick();
    check("mr_pre_cnt", counter, 6);
    reset = 1'b0; pause = 1'b1; abort = 1'b1;
    tick();
    check("mr_counter", counter, 0);
    check("mr_pass", pass_idx, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    reset = 1'b1; pause = 1'b0; abort = 1'b0;
    tick();
    check("mr_idle_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sequence_counter_ctrl.md
# sequence_counter_ctrl

Controller that sequences a WIDTH-bit sequence counter through a programmed range for a programmed number of passes. It takes start, pause and abort commands from a host and owns the counter register. It reports progress through busy and a one-cycle done pulse. It sits between control logic and any consumer of the counter value, and replaces a free-running sequence counter wherever runs must be bounded and restartable.

## Interface
- WIDTH, 4, counter and range width
- PASS_W, 4, pass-count width
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- start  input  1  run request, sampled only in IDLE
- cfg_first  input  WIDTH  first counter value of each pass
- cfg_last  input  WIDTH  last counter value of each pass
- cfg_passes  input  PASS_W  number of passes (0 treated as 1)
- pause  input  1  hold counter while in RUN
- abort  input  1  terminate run, no done
- counter  output  WIDTH  current counter value
- pass_idx  output  PASS_W  current pass index, 0-based
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse on normal completion

## Operation
- States: IDLE, RUN, DONE.
- Reset (reset==0 at a clock edge) sets:
  - state = IDLE
  - counter = 0, pass_idx = 0
  - busy = 0, done = 0
  - latched cfg registers = 0
- IDLE:
  - start==1 latches cfg_first, cfg_last and cfg_passes into internal registers.
  - Same edge: counter <= cfg_first, pass_idx <= 0, go to RUN.
  - Config inputs are ignored outside this latch edge.
- RUN, evaluated in priority order:
  - abort: go to IDLE, counter and pass_idx hold, no done.
  - pause: hold all state.
  - counter != last: counter steps by one (direction below).
  - counter == last and pass_idx == passes-1: go to DONE, counter holds at last.
  - counter == last otherwise: counter <= first, pass_idx <= pass_idx+1.
- DONE: done=1 for exactly this cycle, then unconditionally IDLE. start is ignored in DONE.
- start in RUN or DONE is ignored (no queuing).
- first==last: each pass occupies one RUN cycle.
- Arithmetic is modulo 2^WIDTH. Up-count from last 4'hF wraps to 0. pass_idx never exceeds passes-1.
- Reset mid-run overrides abort/pause and returns to the reset values the next edge.

## Timing
- Start edge N: counter==first and busy==1 visible after edge N.
- Unpaused run of L values per pass and P passes: busy high for L·P cycles, done high the following cycle, busy low during done.
- Pause has zero-cycle latency: a cycle with pause==1 produces no step.
- abort takes effect at the sampling edge. busy is low the next cycle.
- Earliest restart: the cycle after done (the IDLE cycle).
- Outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SEQ_CTRL_DOWN_EN defined: if latched first > last, the counter decrements from first to last. Otherwise it increments.
- Not defined: the counter always increments, wrapping through 2^WIDTH-1 to 0 when first > last. Example: first=14, last=1 gives 14, 15, 0, 1.

## Structure
- Shared package seq_ctrl_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - default WIDTH/PASS_W constants
  - a step-direction helper function
- One sub-module: seq_step_counter, the WIDTH-bit counter register with load, enable, direction and terminal-match output. The FSM and pass counter stay in the top level.

## Test plan
- Reset held low 2 cycles with start=1 -> counter=0, busy=0, done=0. Release, start pulse with first=2, last=5, passes=1 -> counter 2,3,4,5 over 4 busy cycles, done pulse on the 5th cycle, then IDLE.
- first=0, last=3, passes=3 -> sequence 0..3 repeated 3 times, pass_idx 0,1,2, busy 12 cycles, single done.
- Same as the previous run, plus pause high for 3 cycles while counter=2 -> counter holds at 2 for 3 cycles, busy 15 cycles total.
- abort asserted at counter=1 of first=0, last=7 -> busy low next cycle, counter holds 1, no done. Restart works next cycle.
- first=14, last=1, passes=1:
  - Without the macro: 14, 15, 0, 1 then done.
  - With SEQ_CTRL_DOWN_EN: 14 down to 1 (14 values) then done.
- Edge cases:
  - first=last=9, passes=0 -> one RUN cycle with counter=9, then done.
  - start pulsed during RUN -> ignored.
  - reset low mid-run -> all outputs reset next edge.
